// File: rtl/frqdiv_ctrl.sv
// Programmable square-wave divider with glitch-free divisor updates at period boundaries.
// Optional burst mode (fixed number of periods, then done pulse) enabled by FRQDIV_CTRL_BURST_EN.
module frqdiv_ctrl #(
    parameter int W       = 16,
    parameter int DEF_DIV = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] div_in,
    input  logic         div_wr,
    output logic         div_busy,
    output logic         div_ack,
    output logic [W-1:0] div_cur,
    output logic         s_out,
    output logic         tick,
    output logic         running
`ifdef FRQDIV_CTRL_BURST_EN
    ,
    input  logic [15:0]  burst_len,
    output logic         done
`endif
);

    typedef enum logic [1:0] {
        ST_STOP  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam logic [W-1:0] ONE   = W'(1);
    localparam logic [W-1:0] TWO   = W'(2);
    localparam logic [W-1:0] DEF_D = (DEF_DIV < 2) ? TWO : W'(DEF_DIV);

    state_t         state_q, state_d;
    logic [W-1:0]   cnt_q, cnt_d;
    logic [W-1:0]   div_q, div_d;
    logic [W-1:0]   pend_q, pend_d;
    logic           busy_q, busy_d;
    logic           ack_q, ack_d;
    logic           s_out_q, s_out_d;
    logic           tick_q, tick_d;

    logic           active;
    logic           wrap;
    logic           apply;
    logic           run_next;

`ifdef FRQDIV_CTRL_BURST_EN
    logic [15:0]    blen_q, blen_d;
    logic [15:0]    bcnt_q, bcnt_d;
    logic           done_q, done_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_STOP;
            cnt_q   <= '0;
            div_q   <= DEF_D;
            pend_q  <= '0;
            busy_q  <= 1'b0;
            ack_q   <= 1'b0;
            s_out_q <= 1'b0;
            tick_q  <= 1'b0;
`ifdef FRQDIV_CTRL_BURST_EN
            blen_q  <= '0;
            bcnt_q  <= '0;
            done_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            pend_q  <= pend_d;
            busy_q  <= busy_d;
            ack_q   <= ack_d;
            s_out_q <= s_out_d;
            tick_q  <= tick_d;
`ifdef FRQDIV_CTRL_BURST_EN
            blen_q  <= blen_d;
            bcnt_q  <= bcnt_d;
            done_q  <= done_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        div_d    = div_q;
        pend_d   = pend_q;
        busy_d   = busy_q;
        ack_d    = 1'b0;
`ifdef FRQDIV_CTRL_BURST_EN
        blen_d   = blen_q;
        bcnt_d   = bcnt_q;
        done_d   = 1'b0;
`endif

        active = (state_q != ST_STOP);
        wrap   = active && (cnt_q == (div_q - ONE));

        // A write landing on the apply edge wins and postpones application,
        // so back-to-back writes still produce a single acknowledge.
        apply = busy_q && !div_wr && ((state_q == ST_STOP) || wrap);

        if (div_wr) begin
            pend_d = (div_in < TWO) ? TWO : div_in;
            busy_d = 1'b1;
        end else if (apply) begin
            div_d  = pend_q;
            busy_d = 1'b0;
            ack_d  = 1'b1;
        end

        if (active) begin
            cnt_d = wrap ? '0 : (cnt_q + ONE);
        end else begin
            cnt_d = '0;
        end

        unique case (state_q)
            ST_STOP: begin
                if (en) begin
                    state_d = ST_RUN;
`ifdef FRQDIV_CTRL_BURST_EN
                    blen_d  = (burst_len == 16'd0) ? 16'd1 : burst_len;
                    bcnt_d  = 16'd1;
`endif
                end
            end
            ST_RUN: begin
`ifdef FRQDIV_CTRL_BURST_EN
                if (wrap) begin
                    if (bcnt_q >= blen_q) begin
                        state_d = ST_STOP;
                        done_d  = 1'b1;
                    end else begin
                        bcnt_d  = bcnt_q + 16'd1;
                    end
                end
`else
                // Dropping en exactly on the boundary cycle ends cleanly without a drain period.
                if (!en) begin
                    state_d = wrap ? ST_STOP : ST_DRAIN;
                end
`endif
            end
            ST_DRAIN: begin
                if (en) begin
                    state_d = ST_RUN;
                end else if (wrap) begin
                    state_d = ST_STOP;
                end
            end
            default: begin
                state_d = ST_STOP;
            end
        endcase

        run_next = (state_d != ST_STOP);
        s_out_d  = run_next && (cnt_d >= (div_d >> 1));
        tick_d   = run_next && (cnt_d == '0);
    end

    assign div_busy = busy_q;
    assign div_ack  = ack_q;
    assign div_cur  = div_q;
    assign s_out    = s_out_q;
    assign tick     = tick_q;
    assign running  = (state_q != ST_STOP);
`ifdef FRQDIV_CTRL_BURST_EN
    assign done     = done_q;
`endif

endmodule

// File: doc/frqdiv_ctrl.md
FRQDIV_CTRL -- requirements
Module: frqdiv_ctrl

Interface
REQ-001 SHALL have parameter W, default 16, meaning divisor register width in bits.
REQ-002 SHALL have parameter DEF_DIV, default 2, meaning divisor loaded at reset.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port en  input  1  run request, level.
REQ-006 SHALL have port div_in  input  W  requested divisor.
REQ-007 SHALL have port div_wr  input  1  one-cycle strobe that captures div_in.
REQ-008 SHALL have port div_busy  output  1  high while a captured divisor awaits application.
REQ-009 SHALL have port div_ack  output  1  one-cycle pulse in the cycle a captured divisor becomes active.
REQ-010 SHALL have port div_cur  output  W  active divisor D.
REQ-011 SHALL have port s_out  output  1  registered divided square wave.
REQ-012 SHALL have port tick  output  1  one-cycle pulse on the first cycle of every period.
REQ-013 SHALL have port running  output  1  high in RUN and DRAIN states.

Function
REQ-014 SHALL keep the period counter cnt in the range 0..D-1, incrementing each RUN/DRAIN cycle and wrapping from D-1 to 0; the wrap cycle is the period boundary.
REQ-015 SHALL drive s_out=1 exactly when in RUN/DRAIN with cnt >= D/2 (integer division), giving a low-first wave of period D; s_out SHALL be 0 in STOP.
REQ-016 SHALL implement states STOP, RUN, DRAIN: STOP->RUN when en=1 (cnt=0, tick=1 on the first RUN cycle); RUN->DRAIN when en=0; DRAIN->RUN when en=1 again before the boundary, without a phase change; DRAIN->STOP at the boundary.
REQ-017 SHALL clamp a captured div_in of 0 or 1 to 2.
REQ-018 SHALL capture div_in into a pending register on div_wr and set div_busy on the next cycle.
REQ-019 SHALL, in STOP, apply the pending divisor one cycle after capture: div_cur updates, div_ack pulses and div_busy clears in the same cycle.
REQ-020 SHALL, in RUN/DRAIN, apply the pending divisor only at a period boundary, so that cnt=0 of the new period uses the new D and div_ack coincides with tick.
REQ-021 SHALL, for a div_wr in the boundary cycle itself, defer application to the following boundary.
REQ-022 SHALL let a div_wr while div_busy=1 overwrite the pending value (last write wins), with exactly one div_ack.
REQ-023 SHALL apply a divisor pending at a DRAIN->STOP transition in the first STOP cycle.
REQ-024 SHALL never truncate a period or produce an s_out pulse shorter than floor(D/2) cycles.

Reset
REQ-025 SHALL, while rst_n=0, force state=STOP, cnt=0, div_cur=DEF_DIV (clamped per REQ-017), pending cleared, and s_out, tick, div_ack, div_busy, running all 0.
REQ-026 SHALL, on reset assertion mid-period, drop s_out immediately and discard any pending divisor without a div_ack.

Configuration
REQ-027 SHALL, with FRQDIV_CTRL_BURST_EN defined, add inputs burst_len (16 bits) and output done (1 bit); the STOP->RUN transition latches burst_len (0 treated as 1), the block runs exactly that many full periods, then enters STOP and pulses done for one cycle, and en=0 during the burst has no effect.
REQ-028 SHALL, with FRQDIV_CTRL_BURST_EN undefined, omit burst_len and done and run per REQ-016 only.

Verification
REQ-029 SHALL cover: reset, en=1, D=2 -> tick every 2 cycles, s_out 0,1,0,1…, running=1 one cycle after en.
REQ-030 SHALL cover: RUN with D=4, div_wr div_in=7 at cnt=1 -> two more D=4 cycles, then div_ack with tick and period 7 (s_out low 3 cycles, high 4).
REQ-031 SHALL cover: D=6, en deasserted at cnt=2 -> cycles cnt=3..5 complete, s_out high for 3 cycles, then STOP with s_out=0; en=1 reasserted at cnt=4 -> no phase break.
REQ-032 SHALL cover: div_wr 5 then div_wr 9 in consecutive cycles while running -> single div_ack, div_cur=9; div_wr div_in=0 -> div_cur=2.
REQ-033 SHALL cover: rst_n low mid-period with div_busy=1 -> all outputs 0 asynchronously, div_cur=DEF_DIV, no div_ack after release.
REQ-034 SHALL cover, with FRQDIV_CTRL_BURST_EN: burst_len=3, D=4 -> exactly 3 ticks, 12 running cycles, then one done pulse.
